// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state encoding, opcodes and control-word types for the multicycle MIPS controller
package mips_ctrl_pkg;
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11,
      ORIEX   = 4'd12,
      ORIWB   = 4'd13
   } state_t;
   localparam state_t RESET_STATE = FETCH;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;
   localparam logic [2:0] ALUOP_OR    = 3'b011;
   localparam logic [1:0] ALUSRCB_B     = 2'b00;
   localparam logic [1:0] ALUSRCB_4     = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   typedef struct packed {
      logic [2:0] aluop;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       zeroext;
      logic [1:0] pcsrc;
      logic       iord;
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       memwrite;
   } ctrl_t;
endpackage

// File: rtl/ctrl_outdec.sv
// ctrl_outdec: combinational state-to-control-word decode (Moore outputs,
// except FETCH's IR/PC loads which wait for the memory to complete)
module ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);
   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.alusrcb = ALUSRCB_4;
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
         end
         DECODE: ctrl.alusrcb = ALUSRCB_IMMSH;
         MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
         end
         MEMRD: ctrl.iord = 1'b1;
         MEMWB: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         EXECUTE: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_B;
            ctrl.aluop   = ALUOP_RTYPE;
         end
         ALUWB: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         BRANCH: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.branch  = 1'b1;
         end
         ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
         end
         ADDIWB: ctrl.regwrite = 1'b1;
         JUMP: begin
            ctrl.pcsrc   = PCSRC_JUMP;
            ctrl.pcwrite = 1'b1;
         end
         ORIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUSRCB_IMM;
            ctrl.zeroext = 1'b1;
            ctrl.aluop   = ALUOP_OR;
         end
         ORIWB: ctrl.regwrite = 1'b1;
         default: ctrl = '0;
      endcase
   end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath
// with a mem_ready stall handshake on the shared memory
module multicycle_controller
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [2:0] aluop,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       zeroext,
   output logic [1:0] pcsrc,
   output logic       iord,
   output logic       irwrite,
   output logic       pcen,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       memwrite,
   output logic       illegal_op,
   output logic [3:0] state
);
   state_t state_q, state_d;
   logic   op_bad;
   ctrl_t  ctrl;
   always_ff @(posedge clk) begin
      state_q <= reset ? RESET_STATE : state_d;
   end
   always_comb begin
      state_d = FETCH;
      op_bad  = 1'b0;
      case (state_q)
         FETCH:   state_d = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_ORI:       state_d = ORIEX;
               OP_J:         state_d = JUMP;
               default:      op_bad  = 1'b1;
            endcase
         end
         MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
         MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
         EXECUTE: state_d = ALUWB;
         ADDIEX:  state_d = ADDIWB;
         ORIEX:   state_d = ORIWB;
         default: state_d = FETCH;
      endcase
   end
   ctrl_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );
   // Anything that commits architectural state is suppressed during reset
   assign irwrite    = ~reset & ctrl.irwrite;
   assign pcen       = ~reset & (ctrl.pcwrite | (ctrl.branch & zero));
   assign regwrite   = ~reset & ctrl.regwrite;
   assign memwrite   = ~reset & ctrl.memwrite;
   assign illegal_op = ~reset & op_bad;
   assign aluop      = ctrl.aluop;
   assign alusrca    = ctrl.alusrca;
   assign alusrcb    = ctrl.alusrcb;
   assign zeroext    = ctrl.zeroext;
   assign pcsrc      = ctrl.pcsrc;
   assign iord       = ctrl.iord;
   assign regdst     = ctrl.regdst;
   assign memtoreg   = ctrl.memtoreg;
   assign state      = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven cycle-by-cycle vectors plus
// hand-written latency and reset-during-store sequences
module tb_multicycle_controller;
   localparam int R    = 'b000000;
   localparam int LW   = 'b100011;
   localparam int SW   = 'b101011;
   localparam int BEQ  = 'b000100;
   localparam int ADDI = 'b001000;
   localparam int J    = 'b000010;
   localparam int ORI  = 'b001101;
   localparam int BAD  = 'b111111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic [2:0] aluop;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       zeroext;
   logic [1:0] pcsrc;
   logic       iord, irwrite, pcen, regwrite, regdst, memtoreg, memwrite, illegal_op;
   logic [3:0] state;
   logic [20:0] got;
   int n_checks = 0;
   int n_fail = 0;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext),
      .pcsrc(pcsrc), .iord(iord), .irwrite(irwrite), .pcen(pcen),
      .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
      .memwrite(memwrite), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // {state,aluop,alusrca,alusrcb,zeroext,pcsrc,iord,irwrite,pcen,regwrite,regdst,memtoreg,memwrite,illegal_op}
   assign got = {state, aluop, alusrca, alusrcb, zeroext, pcsrc, iord, irwrite,
                 pcen, regwrite, regdst, memtoreg, memwrite, illegal_op};

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        zero;
      logic        mr;
      logic [20:0] exp;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(input int r, o, z, m, st, ao, sa, sb, zx, ps,
                               io, irw, pe, rw, rd, m2r, mw, il);
      vec_t v;
      v.rst  = r[0];
      v.op   = o[5:0];
      v.zero = z[0];
      v.mr   = m[0];
      v.exp  = {st[3:0], ao[2:0], sa[0], sb[1:0], zx[0], ps[1:0], io[0], irw[0],
                pe[0], rw[0], rd[0], m2r[0], mw[0], il[0]};
      return v;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   initial begin
      int cyc;
      //              rst op  z mr  st ao sa sb zx ps io irw pe rw rd m2r mw il
      vecs.push_back(mk(1, R,   0, 0,  0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, R,   0, 1,  0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, LW,  0, 1,  0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, LW,  0, 1,  1, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, LW,  0, 1,  2, 0, 1, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, BAD, 0, 1,  3, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, BAD, 0, 1,  4, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, SW,  0, 0,  0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, SW,  0, 1,  0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, SW,  0, 1,  1, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, SW,  0, 1,  2, 0, 1, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, SW, 0, 0, 5, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, SW,  0, 1,  5, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, BEQ, 1, 1,  0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, BEQ, 1, 1,  1, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, BEQ, 1, 1,  8, 1, 1, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, BEQ, 0, 1,  0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, BEQ, 0, 1,  1, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, BEQ, 0, 1,  8, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, R,   0, 1,  0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, R,   0, 1,  1, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, R,   0, 1,  6, 2, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, R,   0, 1,  7, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, ORI, 0, 1,  0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, ORI, 0, 1,  1, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, ORI, 0, 1, 12, 3, 1, 2, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, ORI, 0, 1, 13, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, ADDI,0, 1,  0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, ADDI,0, 1,  1, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, ADDI,0, 1,  9, 0, 1, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, ADDI,0, 1, 10, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, J,   0, 1,  0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, J,   0, 1,  1, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, J,   0, 1, 11, 0, 0, 0, 0, 2,  0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, BAD, 0, 1,  0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, BAD, 0, 1,  1, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, LW,  0, 1,  0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, LW,  0, 1,  1, 0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, LW,  0, 1,  2, 0, 1, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, LW,  0, 0,  3, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, LW,  0, 0,  3, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, LW,  0, 0,  0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));

      @(posedge clk);
      foreach (vecs[i]) begin
         @(negedge clk);
         reset     = vecs[i].rst;
         op        = vecs[i].op;
         zero      = vecs[i].zero;
         mem_ready = vecs[i].mr;
         #1;
         n_checks++;
         if (got !== vecs[i].exp) begin
            n_fail++;
            $display("FAIL vec%0d: outputs got %b expected %b", i, got, vecs[i].exp);
         end
      end

      @(negedge clk);
      op = LW[5:0];
      mem_ready = 1'b1;
      zero = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (state != 4'd0 && cyc < 20);
      check("lw_latency", cyc, 5);

      op = J[5:0];
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (state != 4'd0 && cyc < 20);
      check("j_latency", cyc, 3);

      op = SW[5:0];
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("sw_stall_state", int'(state), 5);
      check("sw_stall_memwrite", int'(memwrite), 1);
      reset = 1'b1;
      #1;
      check("rst_memwr_memwrite", int'(memwrite), 0);
      check("rst_memwr_state", int'(state), 5);
      @(negedge clk);
      #1;
      check("rst_memwr_next_state", int'(state), 0);
      reset = 1'b0;
      mem_ready = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM sequencing the multicycle MIPS datapath: fetch, decode, execute, memory and writeback.
- Drives the 3-bit aluop consumed by the ALU function decoder, plus all datapath mux selects and write enables.
- Adds a mem_ready stall handshake for the shared instruction/data memory.
- Sits between the instruction register opcode field and the datapath, replacing the single-cycle main decoder.

Parameters:
- RESET_STATE, FETCH, state entered on reset (fixed; not for override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op  in  6  instruction opcode from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- aluop  out  3  000 add, 001 sub, 010 R-type (funct), 011 or
- alusrca  out  1  0 PC, 1 register A
- alusrcb  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
- zeroext  out  1  immediate zero-extended (ori)
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  memory address: 0 PC, 1 ALUOut
- irwrite  out  1  instruction register load
- pcen  out  1  PC load: pcwrite | (branch & zero)
- regwrite  out  1  register file write
- regdst  out  1  0 rt, 1 rd
- memtoreg  out  1  0 ALUOut, 1 memory data
- memwrite  out  1  memory write strobe
- illegal_op  out  1  one-cycle flag: unsupported opcode decoded
- state  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high.
- Reset: reset sampled high puts state in FETCH on the next edge.
- While reset is high, force irwrite, pcen, regwrite, memwrite and illegal_op to 0.
- All other outputs decode from state; non-listed outputs in each state are 0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, ori 001101.
- States (4-bit encoding) and transitions:
  - FETCH(0): alusrcb=01, aluop=000, irwrite=pcwrite=mem_ready. Holds until mem_ready=1, then DECODE.
  - DECODE(1): alusrcb=11, aluop=000. Next by op: lw/sw MEMADR, R EXECUTE, beq BRANCH, addi ADDIEX, ori ORIEX, j JUMP. Any other op: illegal_op=1 this cycle, next FETCH.
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=000. Next MEMRD for lw, MEMWR for sw.
  - MEMRD(3): iord=1. Holds until mem_ready=1, then MEMWB.
  - MEMWB(4): memtoreg=1, regwrite=1. Next FETCH.
  - MEMWR(5): iord=1, memwrite=1, held asserted while stalled. Leaves to FETCH in the cycle mem_ready=1.
  - EXECUTE(6): alusrca=1, alusrcb=00, aluop=010. Next ALUWB.
  - ALUWB(7): regdst=1, regwrite=1. Next FETCH.
  - BRANCH(8): alusrca=1, aluop=001, pcsrc=01, branch=1. Next FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10, aluop=000. Next ADDIWB.
  - ADDIWB(10): regwrite=1. Next FETCH.
  - JUMP(11): pcsrc=10, pcwrite=1. Next FETCH.
  - ORIEX(12): alusrca=1, alusrcb=10, zeroext=1, aluop=011. Next ORIWB.
  - ORIWB(13): regwrite=1. Next FETCH.
  - Unused encodings 14-15: next FETCH; outputs all 0.
- pcen: combinational, pcwrite | (branch & zero). zero is only meaningful in BRANCH.
- Latency with mem_ready held at 1:
  - lw 5 cycles.
  - sw, R, addi, ori 4 cycles.
  - beq, j 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- op is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- Reset mid-instruction: abandon the instruction, return to FETCH, no partial writeback afterwards.

Decomposition:
- mips_ctrl_pkg holds:
  - state enum (4-bit, explicit encodings above)
  - opcode localparams
  - aluop localparams (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_OR)
  - alusrcb/pcsrc select constants
- One sub-module, ctrl_outdec: purely combinational state to control-word decode.
- Top module keeps the state register, next-state logic, reset gating and the pcen gate.

Test Plan:
- Reset held 2 cycles, mem_ready=0 -> state=0, irwrite=pcen=regwrite=memwrite=0. Release with mem_ready=1 -> irwrite=1, pcen=1 in FETCH.
- lw (op=100011), mem_ready=1 -> states 0,1,2,3,4,0. aluop=000 in MEMADR; regwrite=memtoreg=1 only in MEMWB.
- sw, mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, iord=1, then FETCH; regwrite never asserted.
- beq: zero=1 -> pcen=1 in BRANCH. Repeat with zero=0 -> pcen=0. aluop=001, pcsrc=01 in both.
- R-type and ori -> EXECUTE aluop=010, ALUWB regdst=1. ORIEX aluop=011, zeroext=1, then ORIWB regwrite=1, regdst=0.
- op=111111 in DECODE -> illegal_op=1 one cycle, next FETCH. Separately, reset asserted in MEMRD -> FETCH next, no MEMWB regwrite.
